stopwatch_counter: RTL
======================

Name: stopwatch_counter

Overview:
- Time-keeping core of the lab 3 stopwatch. Sits directly downstream of the clock divider block.
- Consumes the divider's countclk (1 Hz), adjclk (2 Hz) and blinkclk (~1.5 Hz) square waves as level inputs in the clk domain.
- Turns their rising edges into single-cycle ticks that drive a BCD MM:SS counter with pause and adjust modes.
- Produces four BCD digits plus per-digit blank flags for the seven-segment display driver.

Parameters:
- MAX_MIN, 59, minute value after which minutes wrap to 00 (legal range 1..99)

Ports:
- clk  input  1  system clock (100 MHz); same clock that drives the divider
- rst  input  1  asynchronous, active-high reset
- countclk  input  1  1 Hz divided clock from the divider; a rising edge means one second has elapsed
- adjclk  input  1  2 Hz divided clock; a rising edge is an adjust step
- blinkclk  input  1  blink-phase clock; high = blank the selected field during adjust
- pause_btn  input  1  debounced single-cycle pulse; toggles the paused flag
- adj  input  1  level; 1 = adjust mode
- sel  input  1  level; field select in adjust: 0 = minutes, 1 = seconds
- lap  input  1  level; display freeze (functional only with the optional feature)
- min_tens  output  4  BCD minutes tens digit
- min_ones  output  4  BCD minutes ones digit
- sec_tens  output  4  BCD seconds tens digit (0..5)
- sec_ones  output  4  BCD seconds ones digit
- blank  output  4  per-digit blank, bit order {min_tens, min_ones, sec_tens, sec_ones}
- paused  output  1  current paused flag

Behaviour:
- Reset: asynchronous, active-high. While rst=1, all of the following hold:
  - all digits 0 (display 00:00), blank=4'b0000, paused=0, lap snapshot cleared to 00:00.
  - countclk/adjclk edge-detect history registers forced to 1, so a divided clock already high at reset release produces no tick.
- Edge detection:
  - cnt_tick = countclk & ~cnt_prev; adj_tick = adjclk & ~adj_prev.
  - History registers update every clk.
  - Each tick is exactly one clk cycle wide, once per source period.
- Latency: a counter update takes effect on the clk edge that samples the tick. Outputs change 1 clk after countclk/adjclk is first sampled high.
- Mode priority, evaluated every cycle:
  1. adj=1 (ADJUST): cnt_tick is ignored. On adj_tick, increment the selected field by 1.
     - Minutes wrap MAX_MIN->00.
     - Seconds wrap 59->00.
     - No carry between fields.
  2. adj=0 and paused=0 (RUN): on cnt_tick, seconds +1.
     - 59->00 with carry: minutes +1.
     - MAX_MIN:59 -> 00:00.
  3. adj=0 and paused=1 (PAUSED): hold all digits.
- pause_btn: toggles paused in any mode. In ADJUST it only affects counting after adj returns to 0.
- Simultaneous pause_btn and cnt_tick: the tick uses the pre-toggle paused value. RUN->pause still counts that tick; PAUSED->run does not count it.
- Leaving ADJUST: no phase realignment. The next count happens at the next natural countclk rising edge.
- adj or sel changing in the same cycle as adj_tick: the sampled (current) values decide the field.
- Arithmetic: BCD per digit.
  - Ones digit 9->0 with carry into tens.
  - Wrap compares the full two-digit value against the limit.
  - An illegal BCD value must never appear on the outputs.
- blank:
  - ADJUST and blinkclk=1: sel=0 -> 4'b1100, sel=1 -> 4'b0011.
  - Otherwise: 4'b0000.
  - blank is registered, so it has 1 clk latency from blinkclk/adj/sel.
- Reset asserted mid-count: immediate return to 00:00 with paused=0. Counting resumes from the first countclk rising edge after release.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - On the cycle lap goes 0->1, the current digits are captured into a snapshot.
  - While lap=1, the digit outputs show the snapshot; the internal counter keeps running per the normal rules.
  - When lap returns to 0, the outputs show the live count on the next cycle.
  - blank applies to whichever value is displayed.
- Undefined: lap is ignored and the outputs always show the live count. No snapshot registers are synthesised.

Test Plan:
- Reset with countclk=1 held, release, hold countclk high 10 cycles -> digits stay 00:00 (no spurious tick); first later countclk rise -> 00:01 one clk after it is sampled.
- RUN from 00:58, three countclk rising edges -> 00:59, 01:00, 01:01; with MAX_MIN=59, preload 59:59 and one edge -> 00:00.
- pause_btn pulse coincident with a cnt_tick while running -> that tick counted (00:05->00:06), paused=1, next 3 ticks leave 00:06; second pulse -> counting resumes at 00:07 on the next edge.
- adj=1, sel=1 from 12:58, three adj_tick -> 12:59, 12:00, 12:01 (minutes unchanged); sel=0 from 59:xx, one adj_tick -> 00:xx; cnt_tick ignored throughout; blank=4'b0011 while blinkclk=1 with sel=1, 4'b0000 while blinkclk=0.
- rst asserted asynchronously mid-cycle at 07:33 with paused=1 -> outputs 00:00, paused=0, blank=0 before the next clk edge.
- STOPWATCH_LAP_EN defined: lap rise at 02:10, 5 ticks -> outputs hold 02:10; lap fall -> 02:15 displayed next cycle. Macro undefined: same stimulus shows 02:11..02:15 live.

Source files
------------

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD MM:SS stopwatch core with pause and adjust modes.
// Defining STOPWATCH_LAP_EN adds a lap snapshot that freezes the displayed digits.
module stopwatch_counter #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       countclk,
    input  logic       adjclk,
    input  logic       blinkclk,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    input  logic       lap,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] blank,
    output logic       paused
);
    localparam logic [7:0] MIN_LIM = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    logic [7:0] min_r, sec_r, min_n, sec_n, min_d, sec_d;
    logic       cnt_prev, adj_prev, cnt_tick, adj_tick;
    // Wrap compares the full two-digit BCD value, so no illegal digit can appear.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v == lim) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction
    always_comb begin
        cnt_tick = countclk & ~cnt_prev;
        adj_tick = adjclk & ~adj_prev;
        sec_n = (adj ? adj_tick & sel : cnt_tick & ~paused) ? bcd_inc(sec_r, 8'h59) : sec_r;
        min_n = (adj ? adj_tick & ~sel : cnt_tick & ~paused & (sec_r == 8'h59)) ? bcd_inc(min_r, MIN_LIM) : min_r;
    end
    // History starts high so a divided clock already high at release is not a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_r    <= 8'h00;
            sec_r    <= 8'h00;
            paused   <= 1'b0;
            cnt_prev <= 1'b1;
            adj_prev <= 1'b1;
            blank    <= 4'b0000;
        end else begin
            min_r    <= min_n;
            sec_r    <= sec_n;
            paused   <= paused ^ pause_btn;
            cnt_prev <= countclk;
            adj_prev <= adjclk;
            blank    <= (adj & blinkclk) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
        end
    end
`ifdef STOPWATCH_LAP_EN
    logic       lap_q;
    logic [7:0] min_s, sec_s;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q <= 1'b0;
            min_s <= 8'h00;
            sec_s <= 8'h00;
        end else begin
            lap_q <= lap;
            if (lap & ~lap_q) begin
                min_s <= min_r;
                sec_s <= sec_r;
            end
        end
    end
    assign min_d = lap_q ? min_s : min_r;
    assign sec_d = lap_q ? sec_s : sec_r;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign min_d = min_r;
    assign sec_d = sec_r;
`endif
    assign {min_tens, min_ones} = min_d;
    assign {sec_tens, sec_ones} = sec_d;
endmodule
